vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares one single-port synchronous video RAM between two requesters: the display line-prefetch engine, which issues bursts, and the CPU port, which issues single-word read/write accesses.
- Sits between the VGA timing/pixel pipeline and the VRAM macro.
- The display has priority, but the CPU is guaranteed a periodic slot during bursts.
- Read data is returned to the correct requester through a latency-matched tag pipeline.

Parameters:
ADDR_W, 16, VRAM address width
DATA_W, 8, VRAM word width
MEM_LAT, 2, cycles from mem_en to valid mem_rdata (>=1)
BURST_LEN, 8, words per fetch burst (>=1)
CPU_SLOT, 4, fetch beats between guaranteed CPU yields; 0 = no yield during burst

Ports:
clk  in  1  system clock
rst_n  in  1  reset
fetch_start  in  1  pulse: start burst at fetch_addr
fetch_addr  in  ADDR_W  burst start address, sampled with fetch_start
fetch_busy  out  1  burst issuing or fetch reads outstanding
fetch_rvalid  out  1  fetch read data valid
fetch_rdata  out  DATA_W  fetch read data
fetch_overrun  out  1  sticky: fetch_start seen while busy
cpu_valid  in  1  CPU request valid
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_ready  out  1  CPU request accepted this cycle (valid&&ready)
cpu_rvalid  out  1  CPU read data valid
cpu_rdata  out  DATA_W  CPU read data
mem_en  out  1  VRAM access strobe
mem_we  out  1  VRAM write enable
mem_addr  out  ADDR_W  VRAM address
mem_wdata  out  DATA_W  VRAM write data
mem_rdata  in  DATA_W  VRAM read data, valid MEM_LAT cycles after mem_en

Behaviour:
- Clock and reset: clock clk; reset rst_n, asynchronous, active-low.
- Reset values:
  - All outputs 0; state IDLE; beat and slot counters 0.
  - Tag pipeline cleared: in-flight reads are discarded and produce no rvalid.
  - fetch_overrun cleared only by reset.
- States:
  - IDLE: the CPU owns the memory.
  - BURST: the fetch engine owns the memory, except during yield cycles.
- fetch_start handling:
  - fetch_start with fetch_busy=0 latches fetch_addr, clears the beat and slot counters, and moves to BURST next cycle.
  - The CPU may still be granted in the fetch_start cycle itself.
- Grant decision (one per cycle, combinational):
  - IDLE: cpu_ready=1.
  - BURST: cpu_ready=1 only when CPU_SLOT!=0 && slot_cnt==CPU_SLOT; otherwise cpu_ready=0 and a fetch beat is issued.
  - BURST yield cycle with cpu_valid=0: no yield; the fetch beat issues; slot_cnt holds at CPU_SLOT, so the next cpu_valid is served immediately.
  - BURST yield cycle with cpu_valid=1: the CPU access issues, slot_cnt resets to 0, and no fetch beat is issued.
- Counters:
  - slot_cnt increments per fetch beat and saturates at CPU_SLOT.
  - beat_cnt counts issued beats.
- Burst addressing:
  - Beat k uses address fetch_addr+k, modulo 2^ADDR_W (wraps 0xFFFF->0x0000).
  - After beat BURST_LEN-1 issues, state returns to IDLE the next cycle.
- Memory outputs are registered: a grant in cycle t drives mem_en/mem_we/mem_addr/mem_wdata in cycle t+1. mem_en=0 when nothing is granted.
- Writes: no rvalid is produced. CPU write data passes unchanged.
- Read return path:
  - Tag pipeline depth MEM_LAT+1 records {valid, is_fetch} per issued read.
  - mem_rdata is registered into fetch_rdata or cpu_rdata.
  - The matching rvalid pulses in cycle t+MEM_LAT+2 relative to grant t, i.e. t+4 at default MEM_LAT=2.
  - Only the addressed rdata register updates; the other holds its value.
- Ordering: read returns come back in issue order. Because there is a single memory port, fetch_rvalid and cpu_rvalid never assert in the same cycle.
- fetch_busy:
  - Asserted from the cycle after an accepted fetch_start through the last fetch_rvalid.
  - Deasserts the cycle after the last fetch_rvalid.
- fetch_overrun: fetch_start while fetch_busy=1 is ignored (the burst is unchanged) and sets fetch_overrun.
- Reset mid-burst: immediate return to IDLE; mem_en=0; no further rvalid for outstanding reads.

Test Plan:
- Write path, idle: cpu_valid=1, we=1, addr=0x1234, wdata=0x5A -> cpu_ready=1 same cycle; next cycle mem_en=1, mem_we=1, mem_addr=0x1234, mem_wdata=0x5A; no cpu_rvalid.
- Read path, idle: CPU read addr 0x0042, memory model returns 0xC3 -> cpu_rvalid single pulse 4 cycles after grant, cpu_rdata=0xC3; fetch_rvalid stays 0.
- Burst, no CPU traffic: fetch_start addr=0x00F8 -> mem_addr 0x00F8..0x00FF on 8 consecutive cycles, 8 fetch_rvalid pulses in order; fetch_busy drops the cycle after the 8th.
- Interleave: cpu_valid held (read) across a burst from 0x0100 -> issue order F,F,F,F,C,F,F,F,F (9 mem_en cycles); cpu_ready high only in cycle 5; returns route correctly.
- Wrap and overrun: fetch_start addr=0xFFFC -> addresses 0xFFFC,0xFFFD,0xFFFE,0xFFFF,0x0000..0x0003. A second fetch_start mid-burst is ignored and sets fetch_overrun=1.
- Reset mid-burst: assert rst_n=0 after beat 3 -> all outputs 0 immediately; after release no rvalid pulses and state IDLE (cpu_ready=1).

Source files
------------

// File: rtl/vram_arbiter.sv
// VRAM arbiter: display burst prefetch vs CPU single-word port.
// Registered memory strobes, tag pipeline routes read data back.
module vram_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MEM_LAT   = 2,
  parameter int BURST_LEN = 8,
  parameter int CPU_SLOT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_start,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_busy,
  output logic              fetch_rvalid,
  output logic [DATA_W-1:0] fetch_rdata,
  output logic              fetch_overrun,
  input  logic              cpu_valid,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int SW = (CPU_SLOT > 0) ? $clog2(CPU_SLOT + 1) : 1;
  localparam int PW = $clog2(BURST_LEN + 1) + 1;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] base_q;
  logic [BW-1:0]     beat_q;
  logic [SW-1:0]     slot_q;
  logic [PW-1:0]     pend_q;
  logic [MEM_LAT:0]  tv_q;
  logic [MEM_LAT:0]  tf_q;
  logic              yield;
  logic              last_beat;
  logic              start_ok;
  logic              cpu_gnt;
  logic              fet_gnt;
  logic              issue_rd;

  assign fetch_busy = (state == BURST) || (pend_q != '0);
  assign start_ok   = fetch_start && !fetch_busy;
  assign yield      = (CPU_SLOT != 0) && (slot_q == SW'(CPU_SLOT));
  assign last_beat  = (beat_q == BW'(BURST_LEN - 1));
  assign issue_rd   = (cpu_gnt && !cpu_we) || fet_gnt;

  always_comb begin
    state_nx  = state;
    cpu_ready = 1'b0;
    cpu_gnt   = 1'b0;
    fet_gnt   = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        cpu_ready = rst_n;
        cpu_gnt   = cpu_valid;
        if (start_ok)
          state_nx = BURST;
      end
      (state == BURST): begin
        cpu_ready = rst_n && yield;
        cpu_gnt   = yield && cpu_valid;
        fet_gnt   = !cpu_gnt;
        if (fet_gnt && last_beat)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      base_q <= '0;
      beat_q <= '0;
      slot_q <= '0;
    end else begin
      state <= state_nx;
      if (start_ok) begin
        base_q <= fetch_addr;
        beat_q <= '0;
        slot_q <= '0;
      end else if (fet_gnt) begin
        beat_q <= beat_q + BW'(1);
        // saturate so an idle CPU is served the moment it asks
        if (slot_q != SW'(CPU_SLOT))
          slot_q <= slot_q + SW'(1);
      end else if (cpu_gnt && state == BURST) begin
        slot_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en        <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      fetch_overrun <= 1'b0;
    end else begin
      mem_en    <= cpu_gnt || fet_gnt;
      mem_we    <= cpu_gnt && cpu_we;
      mem_addr  <= fet_gnt ? base_q + ADDR_W'(beat_q) : cpu_addr;
      mem_wdata <= cpu_gnt ? cpu_wdata : '0;
      if (fetch_start && fetch_busy)
        fetch_overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tv_q         <= '0;
      tf_q         <= '0;
      pend_q       <= '0;
      fetch_rvalid <= 1'b0;
      cpu_rvalid   <= 1'b0;
      fetch_rdata  <= '0;
      cpu_rdata    <= '0;
    end else begin
      tv_q         <= {tv_q[MEM_LAT-1:0], issue_rd};
      tf_q         <= {tf_q[MEM_LAT-1:0], fet_gnt};
      pend_q       <= pend_q + PW'(fet_gnt) - PW'(fetch_rvalid);
      fetch_rvalid <= tv_q[MEM_LAT] && tf_q[MEM_LAT];
      cpu_rvalid   <= tv_q[MEM_LAT] && !tf_q[MEM_LAT];
      if (tv_q[MEM_LAT] && tf_q[MEM_LAT])
        fetch_rdata <= mem_rdata;
      if (tv_q[MEM_LAT] && !tf_q[MEM_LAT])
        cpu_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: VRAM model, cycle reference model,
// directed scenarios and a randomized phase.
module tb_vram_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 8;
  localparam int LAT  = 2;
  localparam int BL   = 8;
  localparam int SLOT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fetch_start = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          fetch_busy;
  logic          fetch_rvalid;
  logic [DW-1:0] fetch_rdata;
  logic          fetch_overrun;
  logic          cpu_valid = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ready;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  vram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT),
    .BURST_LEN(BL), .CPU_SLOT(SLOT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_start(fetch_start), .fetch_addr(fetch_addr),
    .fetch_busy(fetch_busy), .fetch_rvalid(fetch_rvalid),
    .fetch_rdata(fetch_rdata), .fetch_overrun(fetch_overrun),
    .cpu_valid(cpu_valid), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int npass = 0;
  int ntot = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d",
                  nm, act, exp, cyc);
  endtask

  function automatic logic [7:0] init_val(input int i);
    return 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
  endfunction

  // VRAM macro model: read data valid MEM_LAT cycles after mem_en
  logic [7:0] vram [65536];
  logic [7:0] ref_mem [65536];
  logic [7:0] dl [LAT];

  initial begin
    for (int i = 0; i < LAT; i++) dl[i] = '0;
    forever @(negedge clk) begin
      mem_rdata = dl[LAT-1];
      for (int i = LAT - 1; i > 0; i--) dl[i] = dl[i-1];
      dl[0] = (mem_en && !mem_we) ? vram[mem_addr] : 8'($urandom);
      if (mem_en && mem_we) vram[mem_addr] = mem_wdata;
    end
  end

  typedef struct {
    int         due;
    bit         f;
    logic [7:0] d;
  } ret_t;

  typedef struct {
    int          c;
    logic [15:0] a;
    bit          we;
    logic [7:0]  d;
  } mev_t;

  typedef struct {
    int         c;
    bit         f;
    logic [7:0] d;
  } rev_t;

  ret_t rq[$];
  mev_t mlog[$];
  rev_t rlog[$];

  bit          in_burst, ovr, em_en, em_we;
  int          beat, since, fpend;
  logic [15:0] base, em_addr;
  logic [7:0]  em_wd, frd, crd;

  task automatic m_reset();
    in_burst = 0; ovr = 0; em_en = 0; em_we = 0;
    beat = 0; since = 0; fpend = 0;
    base = '0; em_addr = '0; em_wd = '0;
    frd = '0; crd = '0;
    rq.delete();
  endtask

  // reference model and per-cycle compare
  initial begin
    bit          exp_rdy, exp_busy, efv, ecv, cg, fg;
    logic [15:0] fa;
    ret_t        r;
    m_reset();
    forever @(negedge clk) begin
      if (!rst_n) begin
        m_reset();
        continue;
      end
      if (mem_en) mlog.push_back('{cyc, mem_addr, mem_we, mem_wdata});
      if (fetch_rvalid) rlog.push_back('{cyc, 1'b1, fetch_rdata});
      if (cpu_rvalid) rlog.push_back('{cyc, 1'b0, cpu_rdata});
      exp_rdy  = !in_burst || (SLOT != 0 && since >= SLOT);
      exp_busy = in_burst || fpend > 0;
      efv = 0;
      ecv = 0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        r = rq.pop_front();
        if (r.f) begin efv = 1; frd = r.d; end
        else begin ecv = 1; crd = r.d; end
      end
      chk("cpu_ready", cpu_ready, exp_rdy);
      chk("fetch_busy", fetch_busy, exp_busy);
      chk("fetch_overrun", fetch_overrun, ovr);
      chk("mem_en", mem_en, em_en);
      if (em_en) begin
        chk("mem_we", mem_we, em_we);
        chk("mem_addr", mem_addr, em_addr);
      end
      if (em_en && em_we) chk("mem_wdata", mem_wdata, em_wd);
      chk("fetch_rvalid", fetch_rvalid, efv);
      chk("cpu_rvalid", cpu_rvalid, ecv);
      chk("fetch_rdata", fetch_rdata, frd);
      chk("cpu_rdata", cpu_rdata, crd);
      if (efv) fpend--;
      cg = 0;
      fg = 0;
      fa = '0;
      if (fetch_start && exp_busy) ovr = 1;
      if (!in_burst) begin
        cg = cpu_valid;
        if (fetch_start && !exp_busy) begin
          in_burst = 1; base = fetch_addr; beat = 0; since = 0;
        end
      end else if (SLOT != 0 && since >= SLOT && cpu_valid) begin
        cg = 1;
        since = 0;
      end else begin
        fg = 1;
        fa = base + 16'(beat);
        beat++;
        since++;
        if (beat == BL) in_burst = 0;
      end
      em_en = cg || fg;
      em_we = cg && cpu_we;
      em_addr = fg ? fa : cpu_addr;
      em_wd = cpu_wdata;
      if (cg && cpu_we) ref_mem[cpu_addr] = cpu_wdata;
      if (cg && !cpu_we)
        rq.push_back('{cyc + LAT + 2, 1'b0, ref_mem[cpu_addr]});
      if (fg) begin
        rq.push_back('{cyc + LAT + 2, 1'b1, ref_mem[fa]});
        fpend++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    cpu_valid = 0;
    cpu_we = 0;
    fetch_start = 0;
  endtask

  int drop_cyc;

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while (fetch_busy && n < lim) begin
      step();
      n++;
    end
    if (n >= lim) chk("wait_idle_timeout", 1, 0);
    drop_cyc = cyc;
  endtask

  logic [15:0] exp_il [9] = '{16'h0100, 16'h0101, 16'h0102, 16'h0103,
                              16'h2000, 16'h0104, 16'h0105, 16'h0106,
                              16'h0107};
  logic [15:0] exp_wr [8] = '{16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF,
                              16'h0000, 16'h0001, 16'h0002, 16'h0003};

  initial begin
    int       t0;
    logic [8:0] rdy;
    logic [15:0] a;
    for (int i = 0; i < 65536; i++) begin
      vram[i] = init_val(i);
      ref_mem[i] = init_val(i);
    end
    vram[16'h0042] = 8'hC3;
    ref_mem[16'h0042] = 8'hC3;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_cpu_ready", cpu_ready, 0);
    chk("rst_busy", fetch_busy, 0);
    chk("rst_overrun", fetch_overrun, 0);
    @(posedge clk);
    #2 rst_n = 1;
    step();
    chk("idle_ready", cpu_ready, 1);

    // CPU write while idle
    mlog.delete(); rlog.delete();
    cpu_valid = 1; cpu_we = 1;
    cpu_addr = 16'h1234; cpu_wdata = 8'h5A;
    t0 = cyc;
    #1 chk("wr_ready", cpu_ready, 1);
    step();
    idle_in();
    repeat (6) step();
    chk("wr_cnt", mlog.size(), 1);
    if (mlog.size() >= 1) begin
      chk("wr_cyc", mlog[0].c, t0 + 1);
      chk("wr_addr", mlog[0].a, 16'h1234);
      chk("wr_we", mlog[0].we, 1);
      chk("wr_data", mlog[0].d, 8'h5A);
    end
    chk("wr_no_rvalid", rlog.size(), 0);

    // CPU read while idle
    mlog.delete(); rlog.delete();
    cpu_valid = 1; cpu_we = 0; cpu_addr = 16'h0042;
    t0 = cyc;
    step();
    idle_in();
    repeat (7) step();
    chk("rd_cnt", rlog.size(), 1);
    if (rlog.size() >= 1) begin
      chk("rd_cyc", rlog[0].c, t0 + 4);
      chk("rd_is_cpu", rlog[0].f, 0);
      chk("rd_data", rlog[0].d, 8'hC3);
    end

    // burst, no CPU traffic
    mlog.delete(); rlog.delete();
    fetch_start = 1; fetch_addr = 16'h00F8;
    step();
    fetch_start = 0;
    wait_idle(100);
    chk("b_cnt", mlog.size(), 8);
    chk("b_ret", rlog.size(), 8);
    for (int k = 0; k < 8; k++) begin
      a = 16'h00F8 + 16'(k);
      if (k < mlog.size()) chk("b_addr", mlog[k].a, a);
      if (k < rlog.size()) begin
        chk("b_f", rlog[k].f, 1);
        chk("b_data", rlog[k].d, init_val(int'(a)));
      end
    end
    if (rlog.size() == 8) chk("b_busy_drop", drop_cyc, rlog[7].c + 1);

    // burst with CPU read held throughout
    mlog.delete(); rlog.delete();
    fetch_start = 1; fetch_addr = 16'h0100;
    step();
    fetch_start = 0;
    cpu_valid = 1; cpu_we = 0; cpu_addr = 16'h2000;
    rdy = '0;
    for (int k = 0; k < 9; k++) begin
      #1 rdy[k] = cpu_ready;
      step();
    end
    idle_in();
    wait_idle(100);
    repeat (2) step();
    chk("il_ready", rdy, 9'h010);
    chk("il_cnt", mlog.size(), 9);
    for (int k = 0; k < 9; k++)
      if (k < mlog.size()) chk("il_addr", mlog[k].a, exp_il[k]);
    chk("il_ret", rlog.size(), 9);
    if (rlog.size() == 9) begin
      chk("il_cpu_route", rlog[4].f, 0);
      chk("il_cpu_data", rlog[4].d, init_val(16'h2000));
      chk("il_f_route", rlog[5].f, 1);
    end

    // wrap-around and overrun
    mlog.delete(); rlog.delete();
    fetch_start = 1; fetch_addr = 16'hFFFC;
    step();
    fetch_start = 0;
    repeat (2) step();
    fetch_start = 1; fetch_addr = 16'h5555;
    step();
    fetch_start = 0;
    wait_idle(100);
    chk("ov_flag", fetch_overrun, 1);
    chk("wr_cnt8", mlog.size(), 8);
    for (int k = 0; k < 8; k++)
      if (k < mlog.size()) chk("wrap_addr", mlog[k].a, exp_wr[k]);

    // reset during a burst
    fetch_start = 1; fetch_addr = 16'h0300;
    step();
    fetch_start = 0;
    repeat (3) step();
    rst_n = 0;
    #1;
    chk("mr_mem_en", mem_en, 0);
    chk("mr_mem_we", mem_we, 0);
    chk("mr_mem_addr", mem_addr, 0);
    chk("mr_mem_wdata", mem_wdata, 0);
    chk("mr_busy", fetch_busy, 0);
    chk("mr_frv", fetch_rvalid, 0);
    chk("mr_crv", cpu_rvalid, 0);
    chk("mr_frd", fetch_rdata, 0);
    chk("mr_crd", cpu_rdata, 0);
    chk("mr_ready", cpu_ready, 0);
    chk("mr_ovr", fetch_overrun, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    rlog.delete();
    repeat (10) step();
    chk("mr_no_rvalid", rlog.size(), 0);
    chk("mr_idle_ready", cpu_ready, 1);

    // randomized traffic
    repeat (1500) begin
      cpu_valid = $urandom_range(0, 3) != 0;
      cpu_we = 1'($urandom_range(0, 1));
      cpu_addr = 16'($urandom);
      cpu_wdata = 8'($urandom);
      fetch_start = $urandom_range(0, 29) == 0;
      fetch_addr = 16'($urandom);
      step();
    end
    idle_in();
    wait_idle(100);
    repeat (8) step();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
